vermicel_load_store_unit: RTL and testbench
===========================================

Name: vermicel_load_store_unit

Overview:
Memory access stage directly downstream of the ALU in the Vermicel core. It takes the ALU result as the effective address of a load or store and runs a single valid/ready transaction on the data bus. It builds the byte-lane strobes and store data, and aligns and sign- or zero-extends load data. It reports completion or error to the control FSM.

Parameters:
MAX_WAIT, 0, bus wait-cycle limit; 0 = wait forever, N>0 = abort after N cycles with bus_ready low.

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; operands sampled this cycle
write  in  1  1 = store, 0 = load
size  in  2  0 byte, 1 half, 2 word, 3 treated as word
unsigned_ld  in  1  1 = zero-extend load data (LBU/LHU)
address  in  32  effective address (ALU result)
store_data  in  32  rs2 value, right-justified
busy  out  1  transaction in progress
done  out  1  one-cycle pulse: access finished OK
error  out  1  one-cycle pulse: misaligned or timeout
load_data  out  32  extended load result, valid when done=1 and write=0; holds value until next done
bus_valid  out  1  bus request
bus_address  out  32  word-aligned address: address[31:2], 2'b00
bus_wstrobe  out  4  byte enables; all zero for loads
bus_wdata  out  32  lane-replicated store data
bus_rdata  in  32  read data, valid in the cycle bus_ready=1
bus_ready  in  1  transaction accept/complete

Behaviour:
- Reset: the unit is in IDLE. busy, done, error and bus_valid are 0. load_data, bus_address, bus_wstrobe and bus_wdata are 0.
- Reset mid-transaction: all outputs clear immediately (asynchronous). No done or error pulse is produced.
- States:
  - IDLE: start=1 latches operands.
    - Aligned access: go to REQ.
    - Misaligned access: go to FAIL (see the optional feature).
  - REQ: bus_valid=1 and busy=1. All bus outputs stay stable until bus_ready=1.
    - bus_ready=1: capture rdata and go to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
  - FAIL: error=1 for one cycle, then IDLE.
- start while busy=1 is ignored. start is also ignored in the DONE and FAIL cycles.
- Latency:
  - start at cycle 0 → bus_valid at cycle 1.
  - bus_ready at cycle k → done at cycle k+1.
  - Minimum start-to-done latency is 2 cycles.
- Store lanes:
  - byte: wdata={4{sd[7:0]}}, wstrobe=4'b0001<<a[1:0]
  - half: wdata={2{sd[15:0]}}, wstrobe=4'b0011<<{a[1],1'b0}
  - word: wdata=sd, wstrobe=4'b1111
- Load:
  - shifted = rdata >> (8*a[1:0]).
  - byte and half results are sign-extended, or zero-extended when unsigned_ld=1.
  - word loads return rdata unchanged.
- Alignment rules:
  - half is misaligned if a[0]=1.
  - word is misaligned if a[1:0]≠0.
  - byte is never misaligned.
- Timeout (MAX_WAIT>0):
  - A counter clears on entry to REQ and increments each REQ cycle with bus_ready=0.
  - When the count reaches MAX_WAIT, bus_valid drops and the unit goes to FAIL.
  - If bus_ready=1 in the same cycle the limit is reached, the transaction completes normally.
- done and error are never both 1.

Optional Feature:
Macro VERMICEL_LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access never reaches the bus. The unit goes IDLE→FAIL, and error pulses in the cycle after start.
- Undefined: misalignment is not checked. The low address bits are forced to natural alignment: half clears a[0], word clears a[1:0]. The access then proceeds normally, and error is caused by timeout only.

Test Plan:
- Store byte: addr=0x0000_1003, sd=0x1234_56AB, size=0, bus_ready after 2 wait cycles → bus_address=0x1000, wstrobe=4'b1000, wdata=0xABAB_ABAB; done exactly 1 cycle after ready; busy high from the cycle after start until ready.
- Load half signed: addr=0x2002, rdata=0x8001_7FFF, size=1 → load_data=0xFFFF_8001. With unsigned_ld=1 → 0x0000_8001. With addr=0x2000 → 0x0000_7FFF.
- Misaligned word: addr=0x3001, size=2.
  - With the macro: bus_valid stays 0 and error pulses at cycle 1.
  - Without it: bus_address=0x3000, done after ready.
- Timeout: MAX_WAIT=4, bus_ready held 0 → error pulse after 4 REQ cycles, bus_valid then 0. Repeat with ready=1 on the 4th cycle → done, no error.
- Back-to-back: start re-asserted during REQ is ignored; start in the cycle after done is accepted; the second access issues with its own operands.
- Reset: assert reset_n=0 during REQ → bus_valid, busy, done and error fall immediately; after release the unit accepts a new start normally.

Source files
------------

// File: rtl/vermicel_load_store_unit.sv
// vermicel_load_store_unit
//   Memory access stage after the ALU. Uses the ALU result as the effective
//   address of a load or store and runs one valid/ready transaction on the
//   data bus. Builds byte strobes and lane-replicated store data, and aligns
//   and sign/zero-extends load data.
//
// Configuration:
//   MAX_WAIT                       bus wait limit (0 = wait forever)
//   `VERMICEL_LSU_MISALIGN_TRAP_EN defined: misaligned accesses fail without
//                                  touching the bus; undefined: the low address
//                                  bits are forced to natural alignment.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               one-cycle request, operands sampled with it
//   write, size,        access kind (size 3 behaves as word)
//   unsigned_ld
//   address, store_data effective address and right-justified store value
//   busy, done, error   status to the control FSM (done/error are pulses)
//   load_data           extended load result, held until the next load done
//   bus_*               data bus request/response
module vermicel_load_store_unit #(
  parameter int MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        write,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] load_data,
  output logic        bus_valid,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_wstrobe,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2, FAIL = 2'd3} state_t;

  state_t      state, state_next;
  logic        accept;
  logic        is_byte, is_half;
  logic [1:0]  lane;
  logic        misaligned_trap;
  logic        timeout;
  logic [3:0]  strobe_c;
  logic [31:0] wdata_c;
  logic        write_reg, unsigned_reg;
  logic [1:0]  size_reg, lane_reg;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  assign accept  = (state == IDLE) && start;
  assign is_byte = (size == 2'd0);
  assign is_half = (size == 2'd1);

`ifdef VERMICEL_LSU_MISALIGN_TRAP_EN
  assign misaligned_trap = (is_half && address[0]) ||
                           (!is_byte && !is_half && (address[1:0] != 2'b00));
  assign lane = address[1:0];
`else
  // Without the trap, half/word accesses are silently forced to natural alignment.
  assign misaligned_trap = 1'b0;
  assign lane = is_byte ? address[1:0] : (is_half ? {address[1], 1'b0} : 2'b00);
`endif

  // Store lanes; lane[0] is always 0 for halfwords here, so <<lane == <<{a[1],0}.
  always_comb begin
    strobe_c = 4'b0000;
    wdata_c  = store_data;
    if (is_byte) begin
      wdata_c  = {4{store_data[7:0]}};
      strobe_c = 4'b0001 << lane;
    end else if (is_half) begin
      wdata_c  = {2{store_data[15:0]}};
      strobe_c = 4'b0011 << lane;
    end else begin
      strobe_c = 4'b1111;
    end
    if (!write) strobe_c = 4'b0000;
  end

  // Load alignment and extension from the latched access description.
  assign shifted = bus_rdata >> {lane_reg, 3'b000};
  always_comb begin
    load_ext = bus_rdata;
    case (size_reg)
      2'd0:    load_ext = unsigned_reg ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = unsigned_reg ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = bus_rdata;
    endcase
  end

  generate
    if (MAX_WAIT > 0) begin : g_timeout
      localparam int CW = $clog2(MAX_WAIT + 1);
      logic [CW-1:0] wait_cnt;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                      wait_cnt <= '0;
        else if (accept)                   wait_cnt <= '0;
        else if (state == REQ && !bus_ready) wait_cnt <= wait_cnt + 1'b1;
      end
      // The limit is hit on the MAX_WAIT-th stalled REQ cycle; ready wins over it.
      assign timeout = (state == REQ) && !bus_ready && (wait_cnt == CW'(MAX_WAIT - 1));
    end else begin : g_no_timeout
      assign timeout = 1'b0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = misaligned_trap ? FAIL : REQ;
      REQ: begin
        if (bus_ready)    state_next = DONE;
        else if (timeout) state_next = FAIL;
      end
      DONE:    state_next = IDLE;
      FAIL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy      = (state == REQ);
    bus_valid = (state == REQ);
    done      = (state == DONE);
    error     = (state == FAIL);
  end

  // Operand latch and load capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_address  <= 32'h0;
      bus_wstrobe  <= 4'h0;
      bus_wdata    <= 32'h0;
      write_reg    <= 1'b0;
      unsigned_reg <= 1'b0;
      size_reg     <= 2'd0;
      lane_reg     <= 2'd0;
      load_data    <= 32'h0;
    end else begin
      if (accept) begin
        bus_address  <= {address[31:2], 2'b00};
        bus_wstrobe  <= strobe_c;
        bus_wdata    <= wdata_c;
        write_reg    <= write;
        unsigned_reg <= unsigned_ld;
        size_reg     <= size;
        lane_reg     <= lane;
      end
      if (state == REQ && bus_ready && !write_reg) load_data <= load_ext;
    end
  end

endmodule

// File: tb/tb_vermicel_load_store_unit.sv
module tb_vermicel_load_store_unit;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  size = 2'd0;
  logic        unsigned_ld = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ready = 1'b0;
  logic        busy, done, error, bus_valid;
  logic [31:0] load_data, bus_address, bus_wdata;
  logic [3:0]  bus_wstrobe;

  vermicel_load_store_unit #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .write(write), .size(size),
    .unsigned_ld(unsigned_ld), .address(address), .store_data(store_data),
    .busy(busy), .done(done), .error(error), .load_data(load_data),
    .bus_valid(bus_valid), .bus_address(bus_address), .bus_wstrobe(bus_wstrobe),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    bit          is_load;
    bit          uses_bus;
    logic [31:0] baddr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] ld;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_ld = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input bit wr, input logic [1:0] sz, input bit uns,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic [31:0] rd, input int waits);
    exp_t        e;
    logic [31:0] aa;
    logic [7:0]  b;
    logic [15:0] h;
    e.err = 1'b0; e.is_load = !wr; e.uses_bus = 1'b1; aa = a;
`ifdef VERMICEL_LSU_MISALIGN_TRAP_EN
    if ((sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00)) begin
      e.err = 1'b1; e.uses_bus = 1'b0;
    end
`else
    if (sz == 2'd1) aa[0] = 1'b0;
    else if (sz >= 2'd2) aa[1:0] = 2'b00;
`endif
    if (e.uses_bus && (waits < 0 || waits >= MW)) e.err = 1'b1;
    e.baddr = {a[31:2], 2'b00};
    case (sz)
      2'd0: begin
        e.wdata = {4{sd[7:0]}};
        case (aa[1:0])
          2'd0: begin e.strb = 4'b0001; b = rd[7:0];   end
          2'd1: begin e.strb = 4'b0010; b = rd[15:8];  end
          2'd2: begin e.strb = 4'b0100; b = rd[23:16]; end
          default: begin e.strb = 4'b1000; b = rd[31:24]; end
        endcase
        e.ld = uns ? {24'h0, b} : {{24{b[7]}}, b};
      end
      2'd1: begin
        e.wdata = {2{sd[15:0]}};
        e.strb  = aa[1] ? 4'b1100 : 4'b0011;
        h       = aa[1] ? rd[31:16] : rd[15:0];
        e.ld    = uns ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: begin
        e.wdata = sd; e.strb = 4'b1111; e.ld = rd;
      end
    endcase
    if (!wr) e.strb = 4'b0000;
    return e;
  endfunction

  // Scoreboard side: bus fields while a request is up, status on completion.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n) begin
      if (done && error) check("done_and_error", 32'd1, 32'd0);
      if (bus_valid && sb.size() > 0) begin
        check("bus_address", bus_address, sb[0].baddr);
        check("bus_wstrobe", {28'h0, bus_wstrobe}, {28'h0, sb[0].strb});
        if (!sb[0].is_load) check("bus_wdata", bus_wdata, sb[0].wdata);
      end
      if (done || error) begin
        if (sb.size() == 0) check("unexpected_completion", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("status", {30'h0, done, error}, {30'h0, !e.err, e.err});
          if (!e.err && e.is_load) last_ld = e.ld;
          check("load_data", load_data, last_ld);
          if (error) check("valid_on_error", {31'h0, bus_valid}, 32'd0);
        end
      end
    end
  end

  task automatic access(input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rd, input int waits, input bit poke);
    exp_t e;
    int   n, cyc;
    e = model(wr, sz, uns, a, sd, rd, waits);
    @(posedge clk); #1;
    start = 1'b1; write = wr; size = sz; unsigned_ld = uns; address = a; store_data = sd;
    sb.push_back(e);
    $display("access wr=%0b size=%0d uns=%0b addr=%08h sd=%08h rd=%08h waits=%0d",
             wr, sz, uns, a, sd, rd, waits);
    @(posedge clk); #1;
    start = 1'b0; address = 32'hDEAD_BEEF; store_data = ~sd; size = ~sz; write = ~wr;
    if (e.uses_bus) check("valid_latency", {31'h0, bus_valid}, 32'd1);
    else begin
      check("trap_error", {31'h0, error}, 32'd1);
      check("trap_valid", {31'h0, bus_valid}, 32'd0);
    end
    n = 0; cyc = 0;
    while (!(done || error) && cyc < 40) begin
      check("busy", {31'h0, busy}, 32'd1);
      if (poke && n == 1) begin
        start = 1'b1; address = 32'h0000_0F00; store_data = 32'h5555_5555;
      end
      bus_ready = (n == waits);
      bus_rdata = (n == waits) ? rd : $urandom;
      n++; cyc++;
      @(posedge clk); #1;
      start = 1'b0;
      if (bus_ready) check("done_latency", {31'h0, done}, 32'd1);
      bus_ready = 1'b0;
    end
    if (cyc >= 40) check("cycle_budget", 32'd0, 32'd1);
    if (e.uses_bus && waits < 0) check("timeout_cycles", n, MW);
  endtask

  initial begin
    #12;
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_error", {31'h0, error}, 32'd0);
    check("rst_valid", {31'h0, bus_valid}, 32'd0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_bus_address", bus_address, 32'h0);
    check("rst_wstrobe", {28'h0, bus_wstrobe}, 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;

    access(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h1234_56AB, 32'h0, 2, 1'b0);
    access(1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 0, 1'b0);
    access(1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 1, 1'b0);
    access(1'b0, 2'd1, 1'b0, 32'h0000_2000, 32'h0, 32'h8001_7FFF, 0, 1'b0);
    access(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0, 32'hCAFE_F00D, 1, 1'b0);
    access(1'b1, 2'd1, 1'b0, 32'h0000_3003, 32'hAAAA_BBCC, 32'h0, 0, 1'b0);
    access(1'b0, 2'd0, 1'b0, 32'h0000_4001, 32'h0, 32'h1234_80FF, 0, 1'b0);
    access(1'b0, 2'd3, 1'b0, 32'h0000_4004, 32'h0, 32'h7654_3210, 0, 1'b0);
    access(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 32'h0, -1, 1'b0);
    access(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 32'h1111_2222, 3, 1'b0);
    access(1'b1, 2'd2, 1'b0, 32'h0000_6000, 32'h0BAD_F00D, 32'h0, 3, 1'b1);
    access(1'b1, 2'd1, 1'b0, 32'h0000_6002, 32'h0000_9876, 32'h0, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      int w;
      w = int'($urandom_range(0, 6));
      if (w == 6) w = -1;
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, w, 1'b0);
    end

    // Reset in the middle of a request.
    @(posedge clk); #1;
    start = 1'b1; write = 1'b0; size = 2'd2; address = 32'h0000_7000;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", {31'h0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    $display("reset asserted during request");
    check("mid_rst_valid", {31'h0, bus_valid}, 32'd0);
    check("mid_rst_busy", {31'h0, busy}, 32'd0);
    check("mid_rst_done", {31'h0, done}, 32'd0);
    check("mid_rst_error", {31'h0, error}, 32'd0);
    check("mid_rst_address", bus_address, 32'h0);
    sb.delete();
    last_ld = 32'h0;
    @(posedge clk); #1 reset_n = 1'b1;
    access(1'b0, 2'd0, 1'b1, 32'h0000_8002, 32'h0, 32'h00C3_0000, 1, 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
